// File: rtl/vt52_pkg.sv
// Shared screen geometry and fill-FSM state encoding for the VT52 text path.
package vt52_pkg;

  localparam int ROWS        = 25;
  localparam int COLS        = 80;
  localparam int ROW_BITS    = $clog2(ROWS);
  localparam int COL_BITS    = $clog2(COLS);
  localparam int ADDR_BITS   = 11;
  localparam int SCREEN_SIZE = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester alternating arbiter: command vs fill, with a one-bit turn flag
// that only flips when both sides competed in the same cycle.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req_cmd_i,
  input  logic req_fill_i,
  output logic gnt_cmd_o,
  output logic gnt_fill_o,
  output logic turn_fill_o
);

  logic turn_q, turn_d;

  always_comb begin
    gnt_cmd_o  = 1'b0;
    gnt_fill_o = 1'b0;
    turn_d     = turn_q;
    if (!reset) begin
      if (req_cmd_i && req_fill_i) begin
        gnt_cmd_o  = !turn_q;
        gnt_fill_o = turn_q;
        turn_d     = !turn_q;
      end else begin
        gnt_cmd_o  = req_cmd_i;
        gnt_fill_o = req_fill_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) turn_q <= 1'b0;
    else       turn_q <= turn_d;
  end

  assign turn_fill_o = turn_q;

endmodule

// File: rtl/char_write_arbiter.sv
// Merges command-handler writes and block-fill runs onto the single char
// buffer write port; the fill engine walks addresses with screen wrap.
module char_write_arbiter #(
  parameter int ROWS      = vt52_pkg::ROWS,
  parameter int COLS      = vt52_pkg::COLS,
  parameter int ADDR_BITS = vt52_pkg::ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           cmd_char,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 fill_start,
  input  logic [ADDR_BITS-1:0] fill_addr,
  input  logic [ADDR_BITS:0]   fill_len,
  input  logic [7:0]           fill_char,
  output logic                 fill_busy,
  output logic                 fill_done,
  output logic [7:0]           new_char,
  output logic [ADDR_BITS-1:0] new_char_address,
  output logic                 new_char_wen
);
  import vt52_pkg::*;

  localparam int SIZE = ROWS * COLS;
  localparam int LW   = ADDR_BITS + 1;
  localparam logic [LW-1:0]        SIZE_L = LW'(SIZE);
  localparam logic [ADDR_BITS-1:0] SIZE_A = ADDR_BITS'(SIZE);
  localparam logic [ADDR_BITS-1:0] LAST_A = ADDR_BITS'(SIZE - 1);

  fill_state_e          state_q;
  logic [ADDR_BITS-1:0] fptr_q, fptr_d, start_addr_d;
  logic [LW-1:0]        remain_q, len_d;
  logic [7:0]           fchar_q;
  logic                 busy_q, done_q;

  logic                 wen_q;
  logic [7:0]           char_q;
  logic [ADDR_BITS-1:0] waddr_q;

  logic gnt_cmd, gnt_fill, turn_fill;

  rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_cmd_i  (cmd_valid),
    .req_fill_i (state_q == FILL),
    .gnt_cmd_o  (gnt_cmd),
    .gnt_fill_o (gnt_fill),
    .turn_fill_o(turn_fill)
  );

  // Ready is known before cmd_valid: only the fill's turn during a run blocks it.
  always_comb begin
    cmd_ready = !reset && !((state_q == FILL) && turn_fill);
  end

  always_comb begin
    len_d        = (fill_len > SIZE_L) ? SIZE_L : fill_len;
    start_addr_d = ({1'b0, fill_addr} >= SIZE_L) ? (fill_addr - SIZE_A) : fill_addr;
    fptr_d       = (fptr_q == LAST_A) ? '0 : fptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      fptr_q   <= '0;
      remain_q <= '0;
      fchar_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fill_start) begin
            fptr_q   <= start_addr_d;
            remain_q <= len_d;
            fchar_q  <= fill_char;
            if (len_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= FILL;
              busy_q  <= 1'b1;
            end
          end
        end
        FILL: begin
          if (gnt_fill) begin
            fptr_q   <= fptr_d;
            remain_q <= remain_q - 1'b1;
            if (remain_q == LW'(1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write port register: data/address hold when nothing was granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q   <= 1'b0;
      char_q  <= '0;
      waddr_q <= '0;
    end else begin
      wen_q <= gnt_cmd | gnt_fill;
      if (gnt_cmd) begin
        char_q  <= cmd_char;
        waddr_q <= cmd_addr;
      end else if (gnt_fill) begin
        char_q  <= fchar_q;
        waddr_q <= fptr_q;
      end
    end
  end

  assign new_char         = char_q;
  assign new_char_address = waddr_q;
  assign new_char_wen     = wen_q;
  assign fill_busy        = busy_q;
  assign fill_done        = done_q;

endmodule

// File: doc/char_write_arbiter.md
CHAR_WRITE_ARBITER -- requirements
Module: char_write_arbiter

Interface
REQ-001 Parameter ROWS, default 25: text rows on screen.
REQ-002 Parameter COLS, default 80: text columns per row.
REQ-003 Parameter ADDR_BITS, default 11: char buffer address width.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_char  in  8  character from command handler.
REQ-007 cmd_addr  in  ADDR_BITS  char buffer address from command handler.
REQ-008 cmd_valid  in  1  command write request.
REQ-009 cmd_ready  out  1  command write accepted this cycle when high with cmd_valid.
REQ-010 fill_start  in  1  single-cycle pulse that starts a fill run.
REQ-011 fill_addr  in  ADDR_BITS  first address of the fill run.
REQ-012 fill_len  in  ADDR_BITS+1  number of cells to fill.
REQ-013 fill_char  in  8  fill character (e.g. 8'h20 for clear).
REQ-014 fill_busy  out  1  fill run in progress.
REQ-015 fill_done  out  1  single-cycle pulse when the fill run completes.
REQ-016 new_char  out  8  write data to the char buffer.
REQ-017 new_char_address  out  ADDR_BITS  write address to the char buffer.
REQ-018 new_char_wen  out  1  write enable to the char buffer.

Function
REQ-019 SIZE = ROWS*COLS (2000 by default); every generated address SHALL be in 0..SIZE-1.
REQ-020 FSM states: IDLE, FILL, DONE.
- IDLE→FILL on fill_start with clamped length ≥1.
- IDLE→DONE on fill_start with fill_len==0.
- FILL→DONE after the last fill write issues.
- DONE→IDLE unconditionally.
REQ-021 fill_start SHALL be ignored outside IDLE.
REQ-022 On fill_start, the block SHALL latch fill_addr, fill_char and min(fill_len, SIZE).
REQ-023 A fill_addr ≥ SIZE SHALL be reduced by SIZE when latched.
REQ-024 Fill address increment SHALL wrap: SIZE-1 → 0.
REQ-025 Write port usage: at most one write per cycle; every output write SHALL be registered, appearing the cycle after the grant.
REQ-026 Arbitration in IDLE and DONE: cmd_ready=1 and every command request SHALL be granted.
REQ-027 Arbitration in FILL: strict alternation.
- When cmd_valid is high, grants SHALL alternate cmd, fill, cmd, fill using a one-bit turn flag.
- The turn flag SHALL reset to cmd.
- The turn flag SHALL toggle only when both requesters were eligible.
- When cmd_valid is low, fill SHALL issue one write every cycle.
REQ-028 cmd_ready SHALL be combinational: low only in FILL when turn==fill.
REQ-029 A granted command SHALL set new_char_wen=1, new_char=cmd_char, new_char_address=cmd_addr next cycle; cmd_addr is passed unmodified.
REQ-030 In a cycle with no grant, new_char_wen SHALL be 0 the next cycle; new_char and new_char_address SHALL hold their previous values.
REQ-031 fill_busy SHALL be 1 exactly in FILL.
REQ-032 fill_done SHALL be 1 exactly in DONE. fill_done is asserted the cycle after the last fill write is granted, coinciding with that write's wen.
REQ-033 A fill of length N SHALL produce exactly N fill writes.

Reset
REQ-034 While reset is high, regardless of state (including mid-fill), the block SHALL force:
- state=IDLE, turn=cmd, counters=0;
- new_char_wen=0, new_char=0, new_char_address=0;
- fill_busy=0, fill_done=0.
An aborted fill is not resumed and generates no fill_done.
REQ-035 cmd_ready SHALL be 0 while reset is high.

Structure
REQ-036 Shared package vt52_pkg SHALL hold:
- ROWS, COLS, ROW_BITS, COL_BITS, ADDR_BITS and SCREEN_SIZE;
- the FSM state enum (IDLE, FILL, DONE).
REQ-037 One sub-module, rr_arb2, SHALL implement the two-requester alternating grant with its turn flag. All other logic is flat.

Verification
REQ-038 Idle command: cmd_valid=1, cmd_addr=5, cmd_char=8'h41 → cmd_ready=1 same cycle; next cycle wen=1, address=5, char=8'h41.
REQ-039 Full clear: fill_start with fill_addr=0, fill_len=2000, fill_char=8'h20, no cmd → 2000 consecutive writes to 0..1999; fill_busy high for 2000 cycles; then fill_done for 1 cycle.
REQ-040 Wrap: fill_addr=1990, fill_len=20 → writes to 1990..1999 then 0..9.
REQ-041 Contention: 10-cell fill with cmd_valid held high → write sequence cmd, fill, cmd, fill…; all 10 fill writes complete; cmd_ready toggles each FILL cycle.
REQ-042 Edge cases:
- fill_len=0 → no fill writes; fill_done one cycle after fill_start.
- fill_len=3000 → exactly 2000 writes.
REQ-043 Reset mid-fill: reset 1 cycle at fill write 50 → next cycle wen=0, fill_busy=0; no fill_done ever; a following cmd write is accepted normally.
